// File: rtl/smart_uart_cmd_bridge.sv
// UART command bridge: passes plain characters through, decodes read/write word
// commands into a single bus access and streams read responses back to the UART.
// Optional inter-byte command timeout is enabled with SU_CMD_TIMEOUT_EN.
module smart_uart_cmd_bridge #(
   parameter logic [7:0]  CMD_RD_WORD    = 8'hF1,
   parameter logic [7:0]  CMD_WR_WORD    = 8'hF2,
   parameter logic [7:0]  CMD_RSP        = 8'hF3,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  char_byte,
   output logic        char_valid,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        ovr_err,
   output logic        tmo_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS, S_RDWAIT, S_RSP
   } state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  char_byte_q, char_byte_d;
   logic        char_valid_q, char_valid_d;
   logic        bus_req_q, bus_req_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        ovr_q, ovr_d;
   logic        tmo_hit;

   function automatic logic [7:0] rsp_byte(input logic [2:0] idx, input logic [31:0] data);
      case (idx)
         3'd0:    rsp_byte = CMD_RSP;
         3'd1:    rsp_byte = data[31:24];
         3'd2:    rsp_byte = data[23:16];
         3'd3:    rsp_byte = data[15:8];
         3'd4:    rsp_byte = data[7:0];
         default: rsp_byte = 8'h00;
      endcase
   endfunction

`ifdef SU_CMD_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_q;
   logic             in_cmd;

   // Cycles since the last accepted command byte while collecting addr/data.
   always_comb begin
      in_cmd    = (state_q == S_ADDR) || (state_q == S_DATA);
      tmo_cnt_d = '0;
      tmo_hit   = 1'b0;
      if (in_cmd && !rx_valid) begin
         if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
         else tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_hit;
      end
   end

   assign tmo_err = tmo_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = |TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
   assign tmo_err        = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      char_byte_d  = char_byte_q;
      char_valid_d = 1'b0;
      tx_byte_d    = tx_byte_q;
      tx_valid_d   = tx_valid_q;
      ovr_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_byte == CMD_RD_WORD || rx_byte == CMD_WR_WORD) begin
                  we_d    = (rx_byte == CMD_WR_WORD);
                  cnt_d   = 2'd0;
                  state_d = S_ADDR;
               end else begin
                  char_byte_d  = rx_byte;
                  char_valid_d = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (rx_valid) begin
               addr_d = {addr_q[23:0], rx_byte};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cnt_d   = 2'd0;
                  state_d = we_q ? S_DATA : S_BUS;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               wdata_d = {wdata_q[23:0], rx_byte};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_BUS;
            end
         end
         S_BUS: begin
            ovr_d = rx_valid;
            if (bus_gnt) state_d = we_q ? S_IDLE : S_RDWAIT;
         end
         S_RDWAIT: begin
            ovr_d = rx_valid;
            if (bus_rvalid) begin
               rdata_d    = bus_rdata;
               idx_d      = 3'd0;
               tx_byte_d  = CMD_RSP;
               tx_valid_d = 1'b1;
               state_d    = S_RSP;
            end
         end
         S_RSP: begin
            ovr_d = rx_valid;
            if (tx_valid_q && tx_ready) begin
               if (idx_q == 3'd4) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  tx_byte_d = rsp_byte(idx_q + 3'd1, rdata_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abandoned partial command: drop back to idle.
      if (tmo_hit) state_d = S_IDLE;

      bus_req_d = (state_d == S_BUS);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         cnt_q        <= 2'd0;
         idx_q        <= 3'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         char_byte_q  <= '0;
         char_valid_q <= 1'b0;
         bus_req_q    <= 1'b0;
         tx_byte_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         char_byte_q  <= char_byte_d;
         char_valid_q <= char_valid_d;
         bus_req_q    <= bus_req_d;
         tx_byte_q    <= tx_byte_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         ovr_q        <= ovr_d;
      end
   end

   assign char_byte  = char_byte_q;
   assign char_valid = char_valid_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = we_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign tx_byte    = tx_byte_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign ovr_err    = ovr_q;

endmodule

// File: doc/smart_uart_cmd_bridge.md
SMART_UART_CMD_BRIDGE -- requirements
Module: smart_uart_cmd_bridge

Interface
REQ-001 SHALL have parameter CMD_RD_WORD, default 8'hF1, read-word command byte.
REQ-002 SHALL have parameter CMD_WR_WORD, default 8'hF2, write-word command byte.
REQ-003 SHALL have parameter CMD_RSP, default 8'hF3, response header byte.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles.
REQ-005 SHALL have clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have rx_byte  in  8  byte from UART receiver.
REQ-008 SHALL have rx_valid  in  1  one-cycle strobe qualifying rx_byte; no backpressure.
REQ-009 SHALL have char_byte  out  8  pass-through character to core-visible RX register.
REQ-010 SHALL have char_valid  out  1  one-cycle strobe qualifying char_byte.
REQ-011 SHALL have bus_req  out  1  memory access request.
REQ-012 SHALL have bus_we  out  1  1=write, 0=read.
REQ-013 SHALL have bus_addr  out  32  word address as received.
REQ-014 SHALL have bus_wdata  out  32  write data.
REQ-015 SHALL have bus_gnt  in  1  request accepted this cycle.
REQ-016 SHALL have bus_rvalid  in  1  read data valid.
REQ-017 SHALL have bus_rdata  in  32  read data.
REQ-018 SHALL have tx_byte  out  8  response byte to UART transmitter.
REQ-019 SHALL have tx_valid  out  1  tx_byte valid; held until tx_ready.
REQ-020 SHALL have tx_ready  in  1  transmitter accepts tx_byte this cycle.
REQ-021 SHALL have busy  out  1  high in every state except IDLE.
REQ-022 SHALL have ovr_err  out  1  one-cycle pulse when an rx byte is dropped.
REQ-023 SHALL have tmo_err  out  1  one-cycle pulse on command timeout.

Function
REQ-024 SHALL implement states IDLE, ADDR, DATA, BUS, RDWAIT, RSP.
REQ-025 In IDLE, rx byte == CMD_RD_WORD or CMD_WR_WORD SHALL latch opcode and go ADDR; no char_valid.
REQ-026 In IDLE, any other rx byte SHALL appear on char_byte with char_valid the following cycle.
REQ-027 ADDR SHALL shift in 4 bytes MSB first into bus_addr; after 4th: read -> BUS, write -> DATA.
REQ-028 DATA SHALL shift in 4 bytes MSB first into bus_wdata; after 4th -> BUS.
REQ-029 bus_req SHALL assert the cycle after the final command byte and hold, with addr/we/wdata stable, until bus_gnt sampled high.
REQ-030 On bus_gnt: write -> IDLE; read -> RDWAIT.
REQ-031 RDWAIT SHALL capture bus_rdata on first cycle bus_rvalid high (the gnt cycle itself excluded), then -> RSP.
REQ-032 RSP SHALL emit 5 bytes: CMD_RSP, rdata[31:24], [23:16], [15:8], [7:0]; each byte advances only on tx_valid&&tx_ready; after 5th -> IDLE.
REQ-033 rx_valid in BUS, RDWAIT or RSP SHALL drop the byte and pulse ovr_err next cycle.
REQ-034 Byte counter SHALL be 2 bits, cleared on entry to ADDR and DATA; no wrap beyond 4 bytes.
REQ-035 bus_req, tx_valid, char_valid SHALL never be high simultaneously with another of them in the same state except char_valid only in IDLE.

Reset
REQ-036 rst SHALL force IDLE asynchronously, abort any in-flight command, discard partial addr/data.
REQ-037 Under reset all outputs SHALL be 0 (bus_addr, bus_wdata, tx_byte, char_byte included).
REQ-038 First rx byte SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-039 Macro SU_CMD_TIMEOUT_EN defined: counter restarts on each accepted byte in ADDR/DATA; reaching TIMEOUT_CYCLES SHALL return to IDLE and pulse tmo_err.
REQ-040 Macro SU_CMD_TIMEOUT_EN undefined: no counter; ADDR/DATA wait indefinitely; tmo_err tied 0.

Verification
REQ-041 Rx F2,00,00,01,00,DE,AD,BE,EF -> one bus_req, we=1, addr=0x00000100, wdata=0xDEADBEEF; no tx bytes.
REQ-042 Rx F1,00,00,01,00; rvalid rdata=0x12345678 -> tx sequence F3,12,34,56,78; busy low after.
REQ-043 Rx 'A','\n' in IDLE -> char_valid twice with 0x41,0x0A; bus_req never asserted.
REQ-044 Read with tx_ready low 10 cycles per byte -> tx_byte stable while tx_valid held; order unchanged.
REQ-045 Rx F1,00 then 150000 idle cycles with SU_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100000 -> tmo_err pulse, IDLE; next 'x' passes through.
REQ-046 rst asserted after 2 addr bytes -> all outputs 0 immediately; following 'A' passes through on char_byte.
